// File: rtl/in_area_scheduler_if.sv
// Consumer-side handshake of in_area_scheduler: active-low data-available,
// ready-for-data, and the tagged classification result.
interface in_area_scheduler_if;
   logic dav_;
   logic rfd;
   logic z;
   logic src;

   modport master (output dav_, output z, output src, input rfd);
   modport slave  (input dav_, input z, input src, output rfd);
endinterface

// File: rtl/in_area_scheduler.sv
// Two ADC channels sharing one |x|+|y| area classifier; each channel keeps one
// buffered sample, and buffered samples are granted round-robin to a dav_/rfd consumer.
module in_area_scheduler (
   input  logic       clock,
   input  logic       reset,
   output logic       soc_a,
   input  logic       eoc_a,
   input  logic [7:0] xa,
   input  logic [7:0] ya,
   output logic       soc_b,
   input  logic       eoc_b,
   input  logic [7:0] xb,
   input  logic [7:0] yb,
   in_area_scheduler_if.master bus,
   output logic [7:0] hits_a,
   output logic [7:0] hits_b
);
   typedef enum logic [1:0] {CH_START, CH_WAIT, CH_READY} ch_state_t;
   typedef enum logic [1:0] {OUT_IDLE, OUT_DAV, OUT_ACK} out_state_t;

   ch_state_t       ch_q [2];
   ch_state_t       ch_d [2];
   logic [1:0]      soc_q, soc_d;
   logic [1:0][7:0] bx_q, bx_d, by_q, by_d;
   logic [1:0][7:0] hits_q, hits_d;
   out_state_t      out_q, out_d;
   logic            dav_q, dav_d;
   logic            z_q, z_d;
   logic            src_q, src_d;
   logic            last_q, last_d;

   logic [1:0]      eoc_in;
   logic [1:0][7:0] x_in, y_in;
   logic [1:0]      ready;
   logic            grant, gsel, z_new;

   function automatic logic classify(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] ax;
      logic [7:0] ay;
      logic [8:0] s;
      ax = x[7] ? 8'(~x + 8'd1) : x;
      ay = y[7] ? 8'(~y + 8'd1) : y;
      s  = {1'b0, ax} + {1'b0, ay};
      return (s >= 9'd32) && (s <= 9'd64);
   endfunction

   assign eoc_in = {eoc_b, eoc_a};
   assign x_in   = {xb, xa};
   assign y_in   = {yb, ya};

   // Only channels already READY before this edge compete; on contention the
   // channel that was not served last wins.
   always_comb begin
      ready = 2'b00;
      for (int i = 0; i < 2; i++) ready[i] = (ch_q[i] == CH_READY);
      grant = (out_q == OUT_IDLE) && bus.rfd && (ready != 2'b00);
      gsel  = (ready == 2'b11) ? ~last_q : ready[1];
      z_new = classify(bx_q[gsel], by_q[gsel]);
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         ch_d[i]   = ch_q[i];
         soc_d[i]  = 1'b0;
         bx_d[i]   = bx_q[i];
         by_d[i]   = by_q[i];
         hits_d[i] = hits_q[i];
         case (ch_q[i])
            CH_START: begin
               soc_d[i] = 1'b1;
               // soc must have been seen high before a low eoc counts as acknowledge
               if (soc_q[i] && !eoc_in[i]) begin
                  ch_d[i]  = CH_WAIT;
                  soc_d[i] = 1'b0;
               end
            end
            CH_WAIT: begin
               if (eoc_in[i]) begin
                  ch_d[i] = CH_READY;
                  bx_d[i] = x_in[i];
                  by_d[i] = y_in[i];
               end
            end
            CH_READY: begin
               if (grant && (gsel == 1'(i))) begin
                  ch_d[i]  = CH_START;
                  soc_d[i] = 1'b1;
                  if (z_new && (hits_q[i] != 8'hFF)) hits_d[i] = hits_q[i] + 8'd1;
               end
            end
            default: ch_d[i] = CH_START;
         endcase
      end
   end

   always_comb begin
      out_d  = out_q;
      dav_d  = dav_q;
      z_d    = z_q;
      src_d  = src_q;
      last_d = last_q;
      case (out_q)
         OUT_IDLE: begin
            dav_d = 1'b1;
            if (grant) begin
               z_d    = z_new;
               src_d  = gsel;
               last_d = gsel;
               dav_d  = 1'b0;
               out_d  = OUT_DAV;
            end
         end
         OUT_DAV: begin
            dav_d = 1'b0;
            if (!bus.rfd) begin
               dav_d = 1'b1;
               out_d = OUT_ACK;
            end
         end
         OUT_ACK: begin
            dav_d = 1'b1;
            if (bus.rfd) out_d = OUT_IDLE;
         end
         default: begin
            dav_d = 1'b1;
            out_d = OUT_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) ch_q[i] <= CH_START;
         soc_q  <= '0;
         bx_q   <= '0;
         by_q   <= '0;
         hits_q <= '0;
         out_q  <= OUT_IDLE;
         dav_q  <= 1'b1;
         z_q    <= 1'b0;
         src_q  <= 1'b0;
         last_q <= 1'b1;
      end else begin
         for (int i = 0; i < 2; i++) ch_q[i] <= ch_d[i];
         soc_q  <= soc_d;
         bx_q   <= bx_d;
         by_q   <= by_d;
         hits_q <= hits_d;
         out_q  <= out_d;
         dav_q  <= dav_d;
         z_q    <= z_d;
         src_q  <= src_d;
         last_q <= last_d;
      end
   end

   assign soc_a    = soc_q[0];
   assign soc_b    = soc_q[1];
   assign hits_a   = hits_q[0];
   assign hits_b   = hits_q[1];
   assign bus.dav_ = dav_q;
   assign bus.z    = z_q;
   assign bus.src  = src_q;
endmodule
